// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between request sources, pc_reg and the pipeline registers.
// slave = the controller, master = the request/consumer side.
interface pipe_hazard_ctrl_if #(
    parameter int STAGES = 4,
    parameter int SRC    = 2,
    parameter int XLEN   = 64,
    parameter int CNT_W  = 32
);
    logic                    jump_en_i;
    logic [XLEN-1:0]         jump_addr_i;
    logic [SRC*STAGES-1:0]   stall_req_i;
    logic [SRC*STAGES-1:0]   flush_req_i;
    logic                    jump_en_o;
    logic [XLEN-1:0]         jump_addr_o;
    logic [STAGES-1:0]       stall_en_o;
    logic [STAGES-1:0]       flush_en_o;
    logic                    pend_o;
    logic [CNT_W-1:0]        perf_stall_o;
    logic [CNT_W-1:0]        perf_flush_o;
    logic [CNT_W-1:0]        perf_redir_o;

    modport slave (
        input  jump_en_i, jump_addr_i, stall_req_i, flush_req_i,
        output jump_en_o, jump_addr_o, stall_en_o, flush_en_o, pend_o,
               perf_stall_o, perf_flush_o, perf_redir_o
    );

    modport master (
        output jump_en_i, jump_addr_i, stall_req_i, flush_req_i,
        input  jump_en_o, jump_addr_o, stall_en_o, flush_en_o, pend_o,
               perf_stall_o, perf_flush_o, perf_redir_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: merges stall/flush masks and holds redirects while pc is stalled.
// Optional saturating perf counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int STAGES = 4,
    parameter int SRC    = 2,
    parameter int XLEN   = 64,
    parameter int JFLUSH = 2,
    parameter int JSTAGE = 2,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   bus
);

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

    localparam logic [STAGES-1:0] ONE     = 1;
    // Bits 1..JFLUSH; the shift wraps to zero when JFLUSH = STAGES-1, which still yields the right mask.
    localparam logic [STAGES-1:0] JF_MASK = (ONE << (JFLUSH + 1)) - ONE - ONE;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   pend_addr;
    logic              latch_addr;
    logic              redir;
    logic [XLEN-1:0]   addr_sel;
    logic [STAGES-1:0] sraw, fraw;
    logic [STAGES-1:0] stall_c, flush_c, jf;

    always_comb begin
        sraw = '0;
        fraw = '0;
        for (int s = 0; s < SRC; s++) begin
            sraw = sraw | bus.stall_req_i[s*STAGES +: STAGES];
            fraw = fraw | bus.flush_req_i[s*STAGES +: STAGES];
        end
    end

    // An older stalled register freezes every younger one.
    always_comb begin
        logic acc;
        acc     = 1'b0;
        stall_c = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc        = acc | sraw[k];
            stall_c[k] = acc;
        end
    end

    always_comb begin
        state_nxt  = state;
        redir      = 1'b0;
        latch_addr = 1'b0;
        addr_sel   = bus.jump_addr_i;
        case (state)
            RUN: begin
                if (bus.jump_en_i) begin
                    if (!stall_c[0]) begin
                        redir = 1'b1;
                    end else begin
                        latch_addr = 1'b1;
                        state_nxt  = PEND;
                    end
                end
            end
            PEND: begin
                addr_sel = pend_addr;
                // Killing the jumper outranks releasing its redirect.
                if (fraw[JSTAGE] && !stall_c[JSTAGE]) begin
                    state_nxt = RUN;
                end else if (!stall_c[0]) begin
                    redir     = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign jf      = redir ? JF_MASK : '0;
    assign flush_c = (fraw | jf) & ~stall_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            pend_addr <= '0;
        end else begin
            state <= state_nxt;
            if (latch_addr) pend_addr <= bus.jump_addr_i;
        end
    end

    assign bus.jump_en_o   = rst & redir;
    assign bus.jump_addr_o = rst ? addr_sel : '0;
    assign bus.stall_en_o  = rst ? stall_c  : '0;
    assign bus.flush_en_o  = rst ? flush_c  : '0;
    assign bus.pend_o      = rst & (state == PEND);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_stall, perf_flush, perf_redir;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
            perf_redir <= '0;
        end else begin
            if (stall_c[0]) perf_stall <= sat_inc(perf_stall);
            if (|flush_c)   perf_flush <= sat_inc(perf_flush);
            if (redir)      perf_redir <= sat_inc(perf_redir);
        end
    end

    assign bus.perf_stall_o = perf_stall;
    assign bus.perf_flush_o = perf_flush;
    assign bus.perf_redir_o = perf_redir;
`else
    assign bus.perf_stall_o = '0;
    assign bus.perf_flush_o = '0;
    assign bus.perf_redir_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (STAGES=4, SRC=2, XLEN=64, JFLUSH=2, JSTAGE=2, CNT_W=4).
module tb_pipe_hazard_ctrl;

    localparam int STAGES = 4;
    localparam int SRC    = 2;
    localparam int XLEN   = 64;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    pipe_hazard_ctrl_if #(.STAGES(STAGES), .SRC(SRC), .XLEN(XLEN), .CNT_W(CNT_W)) hif ();

    pipe_hazard_ctrl #(
        .STAGES(STAGES), .SRC(SRC), .XLEN(XLEN), .JFLUSH(2), .JSTAGE(2), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic je, input logic [63:0] ja,
                         input logic [3:0] s0, input logic [3:0] s1,
                         input logic [3:0] f0, input logic [3:0] f1);
        hif.jump_en_i   = je;
        hif.jump_addr_i = ja;
        hif.stall_req_i = {s1, s0};
        hif.flush_req_i = {f1, f0};
    endtask

    task automatic chk_out(input string tag, input logic je, input logic [63:0] ja,
                           input logic [3:0] st, input logic [3:0] fl, input logic pd);
        chk({tag, ".jump_en"},   hif.jump_en_o,   je);
        chk({tag, ".jump_addr"}, hif.jump_addr_o, ja);
        chk({tag, ".stall"},     hif.stall_en_o,  st);
        chk({tag, ".flush"},     hif.flush_en_o,  fl);
        chk({tag, ".pend"},      hif.pend_o,      pd);
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b0;
        drive(1'b1, 64'h1234, 4'b1111, 4'b0000, 4'b0100, 4'b0000);

        // Reset forces every output low regardless of inputs.
        @(negedge clk);
        chk_out("reset", 1'b0, 64'h0, 4'h0, 4'h0, 1'b0);
        chk("reset.perf_stall", hif.perf_stall_o, 64'd0);
        tick();
        drive(1'b0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;

        // Load-use bubble.
        drive(1'b0, 64'h0, 4'b0011, 4'b0000, 4'b0100, 4'b0000);
        @(negedge clk);
        chk_out("load_use", 1'b0, 64'h0, 4'b0011, 4'b0100, 1'b0);
        tick();

        // Propagation and stall-over-flush.
        drive(1'b0, 64'h0, 4'b0000, 4'b1000, 4'b0100, 4'b0000);
        @(negedge clk);
        chk_out("prop", 1'b0, 64'h0, 4'b1111, 4'b0000, 1'b0);
        tick();

        // RUN jump issues in the same cycle.
        drive(1'b1, 64'h8000_0040, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk_out("run_jump", 1'b1, 64'h8000_0040, 4'b0000, 4'b0110, 1'b0);
        tick();

        // Back-to-back jump, flush on a younger register merges with the jump flush.
        drive(1'b1, 64'h8000_0080, 4'h0, 4'h0, 4'b1000, 4'h0);
        @(negedge clk);
        chk_out("b2b_jump", 1'b1, 64'h8000_0080, 4'b0000, 4'b1110, 1'b0);
        tick();

        // Pending redirect: cycle 0..2 stalled, stall drops in cycle 3.
        drive(1'b1, 64'h8000_0100, 4'h0, 4'b1111, 4'h0, 4'h0);
        @(negedge clk);
        chk_out("pend_c0", 1'b0, 64'h8000_0100, 4'b1111, 4'b0000, 1'b0);
        tick();
        drive(1'b1, 64'h0, 4'h0, 4'b1111, 4'h0, 4'h0);
        @(negedge clk);
        chk_out("pend_c1", 1'b0, 64'h8000_0100, 4'b1111, 4'b0000, 1'b1);
        tick();
        @(negedge clk);
        chk_out("pend_c2", 1'b0, 64'h8000_0100, 4'b1111, 4'b0000, 1'b1);
        tick();
        drive(1'b1, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk_out("pend_c3", 1'b1, 64'h8000_0100, 4'b0000, 4'b0110, 1'b1);
        tick();
        drive(1'b0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk_out("pend_c4", 1'b0, 64'h0, 4'b0000, 4'b0000, 1'b0);
        tick();

        // Cancel: enter PEND, then id_ex is flushed while only pc is stalled.
        drive(1'b1, 64'h8000_0200, 4'h0, 4'b1111, 4'h0, 4'h0);
        tick();
        drive(1'b1, 64'h0, 4'h0, 4'b0001, 4'h0, 4'b0100);
        @(negedge clk);
        chk_out("cancel_c1", 1'b0, 64'h8000_0200, 4'b0001, 4'b0100, 1'b1);
        tick();
        drive(1'b0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk_out("cancel_c2", 1'b0, 64'h0, 4'b0000, 4'b0000, 1'b0);
        tick();

        // Cancel outranks release: pc unstalled and jumper killed together.
        drive(1'b1, 64'h8000_0300, 4'h0, 4'b1111, 4'h0, 4'h0);
        tick();
        drive(1'b1, 64'h0, 4'h0, 4'h0, 4'b0100, 4'h0);
        @(negedge clk);
        chk_out("cancel_prio", 1'b0, 64'h8000_0300, 4'b0000, 4'b0100, 1'b1);
        tick();
        drive(1'b0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("cancel_prio.after", hif.pend_o, 1'b0);
        tick();

        // Reset mid-PEND drops outputs at once and discards the redirect.
        drive(1'b1, 64'h8000_0400, 4'h0, 4'b1111, 4'h0, 4'h0);
        tick();
        @(negedge clk);
        chk("rst_mid.pend_before", hif.pend_o, 1'b1);
        #1 rst = 1'b0;
        #1;
        chk_out("rst_mid", 1'b0, 64'h0, 4'b0000, 4'b0000, 1'b0);
        tick();
        drive(1'b0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        @(negedge clk);
        chk_out("rst_after", 1'b0, 64'h0, 4'b0000, 4'b0000, 1'b0);
        tick();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        chk("perf.clr_stall", hif.perf_stall_o, 64'd0);
        chk("perf.clr_redir", hif.perf_redir_o, 64'd0);
        drive(1'b0, 64'h0, 4'b0001, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 20; i++) tick();
        chk("perf.stall_sat", hif.perf_stall_o, 64'd15);
        chk("perf.flush_idle", hif.perf_flush_o, 64'd0);
        drive(1'b1, 64'h40, 4'h0, 4'h0, 4'h0, 4'h0);
        tick();
        drive(1'b0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("perf.redir", hif.perf_redir_o, 64'd1);
        chk("perf.flush", hif.perf_flush_o, 64'd1);
`else
        drive(1'b1, 64'h40, 4'b0001, 4'h0, 4'b0100, 4'h0);
        for (int i = 0; i < 3; i++) tick();
        drive(1'b0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        chk("perf.off_stall", hif.perf_stall_o, 64'd0);
        chk("perf.off_flush", hif.perf_flush_o, 64'd0);
        chk("perf.off_redir", hif.perf_redir_o, 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
